// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared FSM state, response owner and request-slot types for mem_arbiter
package arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } slot_req_t;
endpackage

// File: rtl/arbiter_slot.sv
// arbiter_slot: single-entry pending request register with load/clear and same-cycle bypass
//   clock, reset : system clock, synchronous active-high reset
//   load         : capture din (ignored while an entry is already held)
//   clear        : drop the entry (it was granted this cycle)
//   held         : registered pending flag
//   pending      : held, or a load accepted this cycle (bypass)
//   q            : request presented to the arbiter (din when bypassing)
module arbiter_slot
  import arbiter_pkg::*;
#(
  parameter type req_t = slot_req_t
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  req_t din,
  output logic held,
  output logic pending,
  output req_t q
);
  req_t r;
  logic ld;
  assign ld = load & ~held;
  assign pending = held | ld;
  assign q = ld ? din : r;
  always_ff @(posedge clock) begin
    if (reset) begin
      held <= 1'b0;
      r <= '0;
    end else begin
      held <= pending & ~clear;
      if (ld) r <= din;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding bridge port between instruction fetch and data access
//   clock, reset                      : system clock, synchronous active-high reset
//   imem_valid/addr -> imem_rdata/ready : fetch requester
//   dmem_valid/addr/wdata/wstrb -> dmem_rdata/ready : data requester (wstrb 0 = load)
//   mem_valid/instr/addr/wdata/wstrb -> mem_rdata/ready : bridge side, request fields registered
//   Build option ARB_ROUND_ROBIN_EN: alternate grants on ties; otherwise data always wins ties.
module mem_arbiter
  import arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    imem_valid,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    imem_ready,
  input  logic                    dmem_valid,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    dmem_ready,
  output logic                    mem_valid,
  output logic                    mem_instr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready
);
  localparam int SW = DATA_WIDTH / 8;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         wstrb;
  } req_t;
  state_t state, next;
  owner_t own;
  req_t din_i, din_d, qi, qd;
  logic held_i, held_d, pend_i, pend_d, cand_i, cand_d;
  logic idle, done, issue, grant_d;
  assign idle = state == IDLE;
  assign done = ~idle & mem_ready;
  assign din_i = '{addr: imem_addr, wdata: '0, wstrb: '0};
  assign din_d = '{addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};
  // A port is blocked only while its transaction is in flight; in the completion cycle it may reload.
  arbiter_slot #(.req_t(req_t)) u_slot_i (
    .clock(clock), .reset(reset),
    .load(imem_valid & ~(state == BUSY_I & ~mem_ready)),
    .clear(issue & ~grant_d), .din(din_i),
    .held(held_i), .pending(pend_i), .q(qi)
  );
  arbiter_slot #(.req_t(req_t)) u_slot_d (
    .clock(clock), .reset(reset),
    .load(dmem_valid & ~(state == BUSY_D & ~mem_ready)),
    .clear(issue & grant_d), .din(din_d),
    .held(held_d), .pending(pend_d), .q(qd)
  );
  // IDLE arbitrates including same-cycle loads; at completion only already-held entries compete.
  assign cand_i = idle ? pend_i : done & held_i;
  assign cand_d = idle ? pend_d : done & held_d;
  assign issue = cand_i | cand_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_i;
  assign grant_d = cand_d & (~cand_i | last_i);
  always_ff @(posedge clock) begin
    if (reset) last_i <= 1'b1;
    else if (issue) last_i <= ~grant_d;
  end
`else
  assign grant_d = cand_d;
`endif
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    own = OWN_NONE;
    if (issue) next = grant_d ? BUSY_D : BUSY_I;
    else if (done) next = IDLE;
    if (done) own = state == BUSY_I ? OWN_I : OWN_D;
  end
  assign imem_ready = own == OWN_I;
  assign dmem_ready = own == OWN_D;
  assign imem_rdata = imem_ready ? mem_rdata : '0;
  assign dmem_rdata = dmem_ready ? mem_rdata : '0;
  // Fetch slot carries zero wdata/wstrb, so the fetch grant drives them as 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_valid <= issue;
      if (issue) begin
        mem_instr <= ~grant_d;
        mem_addr <= grant_d ? qd.addr : qi.addr;
        mem_wdata <= grant_d ? qd.wdata : qi.wdata;
        mem_wstrb <= grant_d ? qd.wstrb : qi.wstrb;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a bridge stub and reference model
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic imem_valid = 1'b0, dmem_valid = 1'b0, mem_ready = 1'b0;
  logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, mem_rdata = '0;
  logic [3:0] dmem_wstrb = '0;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic imem_ready, dmem_ready, mem_valid, mem_instr;
  logic [3:0] mem_wstrb;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct {int cyc; logic instr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} mem_exp_t;
  typedef struct {int cyc; logic port_d; logic [31:0] rdata;} rsp_exp_t;
  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp[$];
  int checks = 0, errors = 0, cyc = 0;

  // reference model: who owns the bridge (0 none, 1 fetch, 2 data) and what each port has queued
  int owner = 0;
  bit pi = 0, pd = 0, last_i = 1;
  logic [31:0] ai, ad, wd;
  logic [3:0] sd;
  // bridge stub
  bit out_busy = 0, fix = 0, slow = 0;
  int cnt = 0;
  logic [31:0] fix_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, req);
    end
  endtask

  task automatic step(input bit r, input bit iv, input logic [31:0] ia,
                      input bit dv, input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
    bit mr, done, pi0, pd0, ci, cd, gd;
    @(negedge clock);
    cyc++;
    mr = 1'b0;
    if (mem_valid) begin
      out_busy = 1;
      cnt = slow ? 10 : int'($urandom_range(0, 3));
    end
    if (out_busy) begin
      if (cnt == 0) begin
        mr = 1'b1;
        out_busy = 0;
      end else cnt--;
    end else if ($urandom_range(0, 19) == 0) mr = 1'b1;
    if (r) begin
      mr = 1'b0;
      out_busy = 0;
    end
    reset = r;
    mem_ready = mr;
    mem_rdata = fix ? fix_val : $urandom;
    imem_valid = iv;
    imem_addr = ia;
    dmem_valid = dv;
    dmem_addr = da;
    dmem_wdata = dw;
    dmem_wstrb = ds;
    if (r) begin
      owner = 0;
      pi = 0;
      pd = 0;
      last_i = 1;
    end else begin
      done = owner != 0 && mr;
      if (done) exp_rsp.push_back('{cyc, owner == 2, mem_rdata});
      pi0 = pi;
      pd0 = pd;
      if (iv && !pi && !(owner == 1 && !done)) begin
        pi = 1;
        ai = ia;
      end
      if (dv && !pd && !(owner == 2 && !done)) begin
        pd = 1;
        ad = da;
        wd = dw;
        sd = ds;
      end
      ci = owner == 0 ? pi : done && pi0;
      cd = owner == 0 ? pd : done && pd0;
      if (ci || cd) begin
`ifdef ARB_ROUND_ROBIN_EN
        gd = cd && (!ci || last_i);
`else
        gd = cd;
`endif
        exp_mem.push_back('{cyc + 1, !gd, gd ? ad : ai, gd ? wd : 32'h0, gd ? sd : 4'h0});
        if (gd) pd = 0;
        else pi = 0;
        last_i = !gd;
        owner = gd ? 2 : 1;
      end else if (done) owner = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    #2;
    chk({tag, "_mem_valid"}, 32'(mem_valid), 0);
    chk({tag, "_mem_instr"}, 32'(mem_instr), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 0);
    chk({tag, "_imem_ready"}, 32'(imem_ready), 0);
    chk({tag, "_dmem_ready"}, 32'(dmem_ready), 0);
    chk({tag, "_imem_rdata"}, imem_rdata, 0);
    chk({tag, "_dmem_rdata"}, dmem_rdata, 0);
  endtask

  // monitor: pops the scoreboard exactly in the cycle an event is due, flags anything unexpected
  mem_exp_t me;
  rsp_exp_t re;
  always @(negedge clock) begin
    #1;
    if (exp_mem.size() > 0 && exp_mem[0].cyc == cyc) begin
      me = exp_mem.pop_front();
      chk("mem_valid", 32'(mem_valid), 1);
      chk("mem_instr", 32'(mem_instr), 32'(me.instr));
      chk("mem_addr", mem_addr, me.addr);
      chk("mem_wdata", mem_wdata, me.wdata);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(me.wstrb));
    end else if (mem_valid) chk("mem_valid_unexpected", 32'(mem_valid), 0);
    if (exp_rsp.size() > 0 && exp_rsp[0].cyc == cyc) begin
      re = exp_rsp.pop_front();
      chk("imem_ready", 32'(imem_ready), 32'(!re.port_d));
      chk("dmem_ready", 32'(dmem_ready), 32'(re.port_d));
      chk("imem_rdata", imem_rdata, re.port_d ? 32'h0 : re.rdata);
      chk("dmem_rdata", dmem_rdata, re.port_d ? re.rdata : 32'h0);
    end else if (imem_ready || dmem_ready) begin
      chk("imem_ready_unexpected", 32'(imem_ready), 0);
      chk("dmem_ready_unexpected", 32'(dmem_ready), 0);
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_zero("reset");
    fix = 1;
    fix_val = 32'hDEADBEEF;
    step(0, 1, 32'h100, 0, 0, 0, 0);
    idle(8);
    fix = 0;
    step(0, 1, 32'h0, 1, 32'h200, 32'h1234_5678, 4'hF);
    idle(12);
    step(0, 0, 0, 1, 32'h300, 32'h0, 4'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h400, 0, 0, 0, 0);
    idle(12);
    step(0, 1, 32'h500, 0, 0, 0, 0);
    step(0, 1, 32'h504, 0, 0, 0, 0);
    step(0, 1, 32'h508, 0, 0, 0, 0);
    idle(12);
    for (int k = 0; k < 24; k++) step(0, 1, 32'h600 + 32'(k * 4), 1, 32'h700 + 32'(k * 4), 32'(k), 4'h3);
    idle(20);
    for (int k = 0; k < 3000; k++)
      step(0, $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0, $urandom, $urandom,
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
    idle(20);
    slow = 1;
    step(0, 0, 0, 1, 32'h800, 32'h0, 4'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h900, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_zero("midreset");
    slow = 0;
    idle(10);
    chk("mem_queue_drained", 32'(exp_mem.size()), 0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
